// File: rtl/nic_inject_queue.sv
// nic_inject_queue
// ----------------
// This is the injection queue at the network interface. It sits just upstream
// of the router's input pipeline registers. Flits from the local PE are
// buffered here. The head flit is offered to the router's injection port with
// first-word-fall-through timing.
//
// Optional feature macro: NIC_INJ_STARVE_EN
//   When it is defined, a head-of-line wait counter drives 'starve'.
//   When it is undefined, 'starve' is tied low.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   in_flit    - flit from the PE
//   in_valid   - PE presents in_flit
//   in_ready   - queue can accept a flit this cycle (not full)
//   out_flit   - head flit offered to the router (0 when empty)
//   out_valid  - a head flit is present
//   out_grant  - router consumes the head flit this cycle
//   count      - current occupancy, 0..DEPTH
//   starve     - head flit has waited STARVE_LIMIT cycles
module nic_inject_queue #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_grant,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  starve
);

  localparam int PTR_W = $clog2(DEPTH);

  // Reject parameter combinations that would silently break pointer wrap,
  // the occupancy range or the 8-bit wait counter.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
      $error("nic_inject_queue: DEPTH must be a power of 2 and at least 2");
    end
    if (CNT_WIDTH != PTR_W + 1) begin : g_badCntWidth
      $error("nic_inject_queue: CNT_WIDTH must equal log2(DEPTH)+1");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_badLimit
      $error("nic_inject_queue: STARVE_LIMIT must be in 1..255");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_write;
  logic                  w_read;

  // Handshake status comes only from the registered count. Because of this, a
  // full queue refuses a new flit even when a grant frees a slot in the same
  // cycle. This keeps in_ready off the router's grant timing path.
  assign in_ready  = (r_count != CNT_WIDTH'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_write   = in_valid && in_ready;
  assign w_read    = out_valid && out_grant;
  assign out_flit  = out_valid ? r_mem[r_rdPtr] : '0;
  assign count     = r_count;

  // Pointer and occupancy bookkeeping. Pointers are exactly log2(DEPTH) bits
  // wide, so they wrap on their own. Reset discards everything queued. It also
  // overrides any write or grant in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_read) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Flit storage is deliberately left unreset. The out_flit mux already hides
  // stale entries whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_write && !reset) begin
      r_mem[r_wrPtr] <= in_flit;
    end
  end

`ifdef NIC_INJ_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_waitCnt;
  logic [7:0] w_waitNext;
  logic       r_starve;

  // The wait counter counts cycles in which the head flit is offered but not
  // taken, and it saturates at the limit. A read or an empty queue restarts it.
  always_comb begin
    w_waitNext = r_waitCnt;
    if (w_read || !out_valid) begin
      w_waitNext = '0;
    end else if (r_waitCnt != LIMIT) begin
      w_waitNext = r_waitCnt + 8'd1;
    end
  end

  // starve is computed from the next counter value and then registered. As a
  // result, it drops on the same edge that consumes the starving flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_waitCnt <= '0;
      r_starve  <= 1'b0;
    end else begin
      r_waitCnt <= w_waitNext;
      r_starve  <= (w_waitNext == LIMIT);
    end
  end

  assign starve = r_starve;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_nic_inject_queue.sv
// tb_nic_inject_queue
// -------------------
// Bench for nic_inject_queue. It drives directed scenarios first and then
// randomized traffic. A queue-based reference model predicts occupancy,
// handshake flags, the head flit and starvation. A scoreboard holds every
// accepted flit, and a monitor pops it when the DUT hands that flit to the
// router.
module tb_nic_inject_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int LIMIT = 15;
`ifdef NIC_INJ_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] inFlit;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] outFlit;
  logic          outValid;
  logic          outGrant;
  logic [CW-1:0] count;
  logic          starve;

  int checks = 0;
  int errors = 0;

  nic_inject_queue #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .in_flit(inFlit), .in_valid(inValid),
    .in_ready(inReady), .out_flit(outFlit), .out_valid(outValid),
    .out_grant(outGrant), .count(count), .starve(starve)
  );

  always #5 clk = ~clk;

  // Reference model state. modelQ holds the flits that should be in the
  // queue. waitCyc counts how long the current head flit has gone ungranted.
  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] sbQ[$];
  int            waitCyc = 0;
  bit            armed = 1'b0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update at each rising edge. It uses the inputs that were driven
  // during the cycle and applies the queue's rules directly.
  always @(posedge clk) begin
    if (reset) begin
      modelQ.delete();
      sbQ.delete();
      waitCyc = 0;
      armed   = 1'b1;
    end else if (armed) begin
      bit rd, wr;
      rd = outGrant && (modelQ.size() != 0);
      wr = inValid && (modelQ.size() != DEPTH);
      if (rd || modelQ.size() == 0) waitCyc = 0;
      else if (waitCyc < LIMIT) waitCyc = waitCyc + 1;
      if (rd) void'(modelQ.pop_front());
      if (wr) begin
        modelQ.push_back(inFlit);
        sbQ.push_back(inFlit);
      end
    end
  end

  // Monitor on the falling edge. It compares visible state against the
  // model. It then pops the scoreboard whenever the DUT presents a flit that
  // the router is granting.
  always @(negedge clk) begin
    if (armed) begin
      logic [DW-1:0] expHead;
      expHead = (modelQ.size() != 0) ? modelQ[0] : '0;
      checkOutput("count", DW'(count), DW'(modelQ.size()));
      checkOutput("in_ready", DW'(inReady), DW'(modelQ.size() != DEPTH));
      checkOutput("out_valid", DW'(outValid), DW'(modelQ.size() != 0));
      checkOutput("out_flit", outFlit, expHead);
      checkOutput("starve", DW'(starve), DW'(STARVE_ON && waitCyc == LIMIT));
      if (outValid && outGrant && !reset) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_underrun", DW'(1), DW'(0));
        end else begin
          checkOutput("sb_order", outFlit, sbQ.pop_front());
        end
      end
    end
  end

  // Drive one cycle of inputs. Returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [DW-1:0] f, input logic g);
    reset    = r;
    inValid  = v;
    inFlit   = f;
    outGrant = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b1; inFlit = 64'hAA; outGrant = 1'b0;

    // Hold reset with a write pending. It must be ignored.
    applyStimulus(1'b1, 1'b1, 64'hAA, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'hAA, 1'b0);
    checkOutput("reset_count", DW'(count), 0);
    checkOutput("reset_flit", outFlit, 0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("idle_ready", DW'(inReady), 1);
    checkOutput("idle_valid", DW'(outValid), 0);

    // Fill to full, then offer a ninth flit that must be refused.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
    checkOutput("full_count", DW'(count), DEPTH);
    checkOutput("full_ready", DW'(inReady), 0);
    applyStimulus(1'b0, 1'b1, 64'h09, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h09, 1'b0);
    checkOutput("full_head", outFlit, 64'h01);

    // Drain the queue in order.
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("drain_ready", DW'(inReady), 1);
    for (int i = 1; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("drain_valid", DW'(outValid), 0);

    // Simultaneous read and write at occupancy 3, wrapping both pointers.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, DW'(64'h100 + i), 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, DW'(64'h200 + i), 1'b1);
    checkOutput("rw_count", DW'(count), 3);

    // Full with a grant. Only the read happens, and the new flit is taken on
    // the next cycle.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, DW'(64'h300 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h55, 1'b1);
    checkOutput("fullgrant_count", DW'(count), 7);
    applyStimulus(1'b0, 1'b1, 64'h55, 1'b0);
    checkOutput("fullgrant_refill", DW'(count), 8);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);

    // Starvation: one flit sits ungranted.
    applyStimulus(1'b0, 1'b1, 64'hBEEF, 1'b0);
    for (int i = 0; i < LIMIT - 1; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("starve_early", DW'(starve), 0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("starve_set", DW'(starve), DW'(STARVE_ON));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("starve_hold", DW'(starve), DW'(STARVE_ON));
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("starve_clear", DW'(starve), 0);
    checkOutput("starve_count", DW'(count), 0);

    // Randomized traffic with occasional resets. The bias changes per block
    // so that the full, empty and steady regimes all occur.
    for (int blk = 0; blk < 8; blk++) begin
      int pv, pg;
      pv = $urandom_range(20, 90);
      pg = $urandom_range(5, 90);
      for (int i = 0; i < 100; i++) begin
        applyStimulus($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < pv,
                      {$urandom, $urandom},
                      $urandom_range(0, 99) < pg);
      end
    end

    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
